cordic_nco_frontend: RTL and testbench

- Upstream feeder for the CORDIC rotation pipeline.
- A phase accumulator (NCO) produces a full-circle phase word each enabled cycle. The block folds that phase into a quadrant plus a residual of ±pi/4.
- Outputs per sample: a pre-rotated, gain-compensated start vector (x, y) and the residual angle in radians. These drive the CORDIC x_in, y_in and angle_in directly, so the CORDIC only converges within ±pi/4.
- valid_out travels alongside the data because the CORDIC pipeline carries no valid of its own.

---
 rtl/cordic_nco_frontend.sv | 99 +++++++++
 tb/tb_cordic_nco_frontend.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_nco_frontend.sv
// NCO phase accumulator with nearest-quadrant fold: produces a pre-rotated,
// gain-compensated start vector and a +/-pi/4 residual angle for a CORDIC rotator.
module cordic_nco_frontend #(
    parameter int PHASE_W = 16,
    parameter int DATA_W  = 16,
    parameter int K_INIT  = 19896,
    parameter int HALF_PI = 25736
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [PHASE_W-1:0]       freq_word,
    input  logic [PHASE_W-1:0]       phase_offset,
    input  logic                     load_phase,
    input  logic [PHASE_W-1:0]       load_value,
    output logic signed [DATA_W-1:0] x_out,
    output logic signed [DATA_W-1:0] y_out,
    output logic signed [DATA_W-1:0] angle_out,
    output logic [1:0]               quadrant_out,
    output logic [PHASE_W-1:0]       phase_out,
    output logic                     valid_out
);

    localparam int QSHIFT = PHASE_W - 2;
    localparam int PROD_W = PHASE_W + DATA_W;
    localparam logic [PHASE_W-1:0]       ROUND = PHASE_W'(1) << (PHASE_W - 3);
    localparam logic signed [DATA_W-1:0] K_POS = DATA_W'(K_INIT);
    localparam logic signed [DATA_W-1:0] K_NEG = DATA_W'(-K_INIT);

    logic [PHASE_W-1:0] acc;
    logic [PHASE_W-1:0] p1;
    logic               v1;

    logic [1:0]                q_nxt;
    logic signed [PHASE_W-1:0] r_nxt;
    logic signed [PROD_W-1:0]  prod;
    logic signed [DATA_W-1:0]  angle_nxt;
    logic signed [DATA_W-1:0]  x_nxt;
    logic signed [DATA_W-1:0]  y_nxt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else if (load_phase) begin
            acc <= load_value;
        end else if (enable) begin
            acc <= acc + freq_word;
        end
    end

    // Stage 1 samples the accumulator before this edge's load/increment lands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p1 <= '0;
            v1 <= 1'b0;
        end else begin
            p1 <= acc + phase_offset;
            v1 <= enable;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        x_nxt = '0;
        y_nxt = '0;
        q_nxt = 2'((p1 + ROUND) >> QSHIFT);
        r_nxt = $signed(p1 - {q_nxt, {QSHIFT{1'b0}}});
        prod  = PROD_W'(r_nxt) * PROD_W'(HALF_PI);
        angle_nxt = DATA_W'(prod >>> QSHIFT);
        case (q_nxt)
            2'd0: x_nxt = K_POS;
            2'd1: y_nxt = K_POS;
            2'd2: x_nxt = K_NEG;
            2'd3: y_nxt = K_NEG;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_out        <= '0;
            y_out        <= '0;
            angle_out    <= '0;
            quadrant_out <= '0;
            phase_out    <= '0;
            valid_out    <= 1'b0;
        end else begin
            x_out        <= x_nxt;
            y_out        <= y_nxt;
            angle_out    <= angle_nxt;
            quadrant_out <= q_nxt;
            phase_out    <= p1;
            valid_out    <= v1;
        end
    end

endmodule

// File: tb/tb_cordic_nco_frontend.sv
// Directed bench for cordic_nco_frontend: quadrant fold, boundaries, wrap,
// enable gaps, load/enable collision and asynchronous mid-stream reset.
module tb_cordic_nco_frontend;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               enable = 1'b0;
    logic               load_phase = 1'b0;
    logic [15:0]        freq_word = '0;
    logic [15:0]        phase_offset = '0;
    logic [15:0]        load_value = '0;
    logic signed [15:0] x_out;
    logic signed [15:0] y_out;
    logic signed [15:0] angle_out;
    logic [1:0]         quadrant_out;
    logic [15:0]        phase_out;
    logic               valid_out;

    int checks = 0;
    int failures = 0;

    cordic_nco_frontend dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .freq_word    (freq_word),
        .phase_offset (phase_offset),
        .load_phase   (load_phase),
        .load_value   (load_value),
        .x_out        (x_out),
        .y_out        (y_out),
        .angle_out    (angle_out),
        .quadrant_out (quadrant_out),
        .phase_out    (phase_out),
        .valid_out    (valid_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_acc(input logic [15:0] value);
        load_phase = 1'b1;
        load_value = value;
        enable     = 1'b0;
        tick();
        load_phase = 1'b0;
    endtask

    task automatic test_reset;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({valid_out, quadrant_out, x_out, y_out, angle_out, phase_out} !== '0) begin
            failures++;
            $display("FAIL reset_async: got v=%0b q=%0d x=%0d y=%0d ang=%0d p=%h, want all zero",
                     valid_out, quadrant_out, x_out, y_out, angle_out, phase_out);
        end
        enable = 1'b1;
        tick();
        tick();
        checks++;
        if ({valid_out, phase_out} !== '0) begin
            failures++;
            $display("FAIL reset_held: got v=%0b p=%h, want v=0 p=0000", valid_out, phase_out);
        end
        enable = 1'b0;
        #3 reset = 1'b1;
    endtask

    task automatic test_quadrants;
        logic [1:0]         eq [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        logic signed [15:0] ex [4] = '{16'sd19896, 16'sd0, -16'sd19896, 16'sd0};
        logic signed [15:0] ey [4] = '{16'sd0, 16'sd19896, 16'sd0, -16'sd19896};
        logic [15:0]        ep [4] = '{16'h0000, 16'h4000, 16'h8000, 16'hC000};
        phase_offset = 16'h0000;
        freq_word    = 16'h4000;
        load_acc(16'h0000);
        enable = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({valid_out, quadrant_out, x_out, y_out, angle_out, phase_out} !==
                {1'b1, eq[i], ex[i], ey[i], 16'sd0, ep[i]}) begin
                failures++;
                $display("FAIL quadrant[%0d]: got v=%0b q=%0d x=%0d y=%0d ang=%0d p=%h, want v=1 q=%0d x=%0d y=%0d ang=0 p=%h",
                         i, valid_out, quadrant_out, x_out, y_out, angle_out, phase_out,
                         eq[i], ex[i], ey[i], ep[i]);
            end
            if (i == 2) enable = 1'b0;
        end
        tick();
        checks++;
        if (valid_out !== 1'b0) begin
            failures++;
            $display("FAIL quadrant_tail: got v=%0b, want v=0", valid_out);
        end
    endtask

    task automatic test_boundaries;
        logic [15:0]        ep [4] = '{16'h2000, 16'h1FFF, 16'hE000, 16'h6000};
        logic [1:0]         eq [4] = '{2'd1, 2'd0, 2'd0, 2'd2};
        logic signed [15:0] ex [4] = '{16'sd0, 16'sd19896, 16'sd19896, -16'sd19896};
        logic signed [15:0] ey [4] = '{16'sd19896, 16'sd0, 16'sd0, 16'sd0};
        logic signed [15:0] ea [4] = '{-16'sd12868, 16'sd12866, -16'sd12868, -16'sd12868};
        freq_word    = 16'h0000;
        phase_offset = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            load_acc(ep[i]);
            enable = 1'b1;
            tick();
            enable = 1'b0;
            tick();
            checks++;
            if ({valid_out, quadrant_out, x_out, y_out, angle_out, phase_out} !==
                {1'b1, eq[i], ex[i], ey[i], ea[i], ep[i]}) begin
                failures++;
                $display("FAIL boundary[%0d]: got v=%0b q=%0d x=%0d y=%0d ang=%0d p=%h, want v=1 q=%0d x=%0d y=%0d ang=%0d p=%h",
                         i, valid_out, quadrant_out, x_out, y_out, angle_out, phase_out,
                         eq[i], ex[i], ey[i], ea[i], ep[i]);
            end
        end
    endtask

    task automatic test_wrap_and_offset;
        logic [15:0]        ep [3] = '{16'hFFF0, 16'h0010, 16'h8000};
        logic [1:0]         eq [3] = '{2'd0, 2'd0, 2'd2};
        logic signed [15:0] ex [3] = '{16'sd19896, 16'sd19896, -16'sd19896};
        logic signed [15:0] ea [3] = '{-16'sd26, 16'sd25, 16'sd0};
        freq_word    = 16'h0020;
        phase_offset = 16'h0000;
        load_acc(16'hFFF0);
        enable = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                enable = 1'b0;
                tick();
            end else if (i == 2) begin
                freq_word    = 16'h0000;
                phase_offset = 16'h8000;
                load_acc(16'h0000);
                enable = 1'b1;
                tick();
                enable = 1'b0;
                tick();
            end else begin
                tick();
            end
            checks++;
            if ({valid_out, quadrant_out, x_out, y_out, angle_out, phase_out} !==
                {1'b1, eq[i], ex[i], 16'sd0, ea[i], ep[i]}) begin
                failures++;
                $display("FAIL wrap[%0d]: got v=%0b q=%0d x=%0d y=%0d ang=%0d p=%h, want v=1 q=%0d x=%0d y=0 ang=%0d p=%h",
                         i, valid_out, quadrant_out, x_out, y_out, angle_out, phase_out,
                         eq[i], ex[i], ea[i], ep[i]);
            end
        end
        phase_offset = 16'h0000;
    endtask

    task automatic test_enable_pattern;
        logic        pat [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [15:0] ep  [7] = '{16'h0000, 16'h0000, 16'h0100, 16'h0200, 16'h0000, 16'h0000, 16'h0000};
        freq_word    = 16'h0100;
        phase_offset = 16'h0000;
        load_acc(16'h0000);
        for (int i = 0; i < 7; i++) begin
            enable = pat[i];
            tick();
            if (i > 0) begin
                checks++;
                if (valid_out !== pat[i-1]) begin
                    failures++;
                    $display("FAIL pattern_valid[%0d]: got v=%0b, want v=%0b", i - 1, valid_out, pat[i-1]);
                end
                if (pat[i-1]) begin
                    checks++;
                    if (phase_out !== ep[i-1]) begin
                        failures++;
                        $display("FAIL pattern_phase[%0d]: got p=%h, want p=%h", i - 1, phase_out, ep[i-1]);
                    end
                end
            end
        end
        enable = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        checks++;
        if ({valid_out, phase_out} !== {1'b1, 16'h0300}) begin
            failures++;
            $display("FAIL pattern_hold: got v=%0b p=%h, want v=1 p=0300", valid_out, phase_out);
        end
    endtask

    task automatic test_load_and_enable;
        freq_word    = 16'h0300;
        phase_offset = 16'h0000;
        load_acc(16'h1000);
        load_phase = 1'b1;
        load_value = 16'h4000;
        enable     = 1'b1;
        tick();
        load_phase = 1'b0;
        tick();
        checks++;
        if ({valid_out, quadrant_out, x_out, y_out, angle_out, phase_out} !==
            {1'b1, 2'd0, 16'sd19896, 16'sd0, 16'sd6434, 16'h1000}) begin
            failures++;
            $display("FAIL load_collide_old: got v=%0b q=%0d x=%0d y=%0d ang=%0d p=%h, want v=1 q=0 x=19896 y=0 ang=6434 p=1000",
                     valid_out, quadrant_out, x_out, y_out, angle_out, phase_out);
        end
        enable = 1'b0;
        tick();
        checks++;
        if ({valid_out, quadrant_out, x_out, y_out, angle_out, phase_out} !==
            {1'b1, 2'd1, 16'sd0, 16'sd19896, 16'sd0, 16'h4000}) begin
            failures++;
            $display("FAIL load_collide_new: got v=%0b q=%0d x=%0d y=%0d ang=%0d p=%h, want v=1 q=1 x=0 y=19896 ang=0 p=4000",
                     valid_out, quadrant_out, x_out, y_out, angle_out, phase_out);
        end
    endtask

    task automatic test_reset_midstream;
        freq_word    = 16'h1000;
        phase_offset = 16'h0123;
        load_acc(16'h0000);
        enable = 1'b1;
        tick();
        tick();
        checks++;
        if (valid_out !== 1'b1) begin
            failures++;
            $display("FAIL midreset_pre: got v=%0b, want v=1", valid_out);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({valid_out, quadrant_out, x_out, y_out, angle_out, phase_out} !== '0) begin
            failures++;
            $display("FAIL midreset_clear: got v=%0b q=%0d x=%0d y=%0d ang=%0d p=%h, want all zero",
                     valid_out, quadrant_out, x_out, y_out, angle_out, phase_out);
        end
        #2 reset = 1'b1;
        tick();
        checks++;
        if (valid_out !== 1'b0) begin
            failures++;
            $display("FAIL midreset_latency: got v=%0b one clock after release, want v=0", valid_out);
        end
        tick();
        checks++;
        if ({valid_out, quadrant_out, x_out, y_out, angle_out, phase_out} !==
            {1'b1, 2'd0, 16'sd19896, 16'sd0, 16'sd457, 16'h0123}) begin
            failures++;
            $display("FAIL midreset_first: got v=%0b q=%0d x=%0d y=%0d ang=%0d p=%h, want v=1 q=0 x=19896 y=0 ang=457 p=0123",
                     valid_out, quadrant_out, x_out, y_out, angle_out, phase_out);
        end
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_quadrants();
        test_boundaries();
        test_wrap_and_offset();
        test_enable_pattern();
        test_load_and_enable();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
